// File: rtl/mure_pkg.sv
// Shared types for the trace front end: functional-unit opcodes, trap cause
// width, the buffered commit entry and the serializer FSM states.
package mure_pkg;

    localparam int unsigned CAUSE_LEN = 5;
    localparam int unsigned ITYPE_LEN = 3;
    // Widest address/tval an entry can hold; module XLEN must not exceed it.
    localparam int unsigned MAX_XLEN  = 64;

    typedef enum logic [3:0] {
        ADD, SUB, EQ, NE, LTS, LTU, GES, GEU,
        JAL, JALR, LOAD, STORE, CSR, MUL, FENCE, OTHER
    } fu_op;

    typedef struct packed {
        logic [MAX_XLEN-1:0]  iaddr;
        fu_op                 op;
        logic                 branch_taken;
        logic                 exception;
        logic                 interrupt;
        logic [CAUSE_LEN-1:0] cause;
        logic [MAX_XLEN-1:0]  tval;
        logic                 resync;
    } entry_t;

    typedef enum logic {
        NORMAL,
        DROP
    } state_t;

endpackage

// File: rtl/commit_serializer.sv
// Collects the per-cycle batch of committed instructions (plus an optional
// trap entry), compacts it into a circular buffer and hands entries one at a
// time to the itype detector. Batches that do not fit are dropped whole; after
// a drop the buffer drains completely before new batches are taken, and the
// first entry taken afterwards is flagged as a resync point.
module commit_serializer
    import mure_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned XLEN            = 64
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NR_COMMIT_PORTS-1:0]             commit_valid_i,
    input  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]   iaddr_i,
    input  fu_op                                   op_i [NR_COMMIT_PORTS],
    input  logic [NR_COMMIT_PORTS-1:0]             branch_taken_i,
    input  logic                                   exception_i,
    input  logic                                   interrupt_i,
    input  logic [CAUSE_LEN-1:0]                   cause_i,
    input  logic [XLEN-1:0]                        tval_i,
    input  logic [XLEN-1:0]                        epc_i,
    input  logic                                   ready_i,
    output logic                                   valid_o,
    output logic [XLEN-1:0]                        iaddr_o,
    output fu_op                                   op_o,
    output logic                                   branch_taken_o,
    output logic                                   exception_o,
    output logic                                   interrupt_o,
    output logic [CAUSE_LEN-1:0]                   cause_o,
    output logic [XLEN-1:0]                        tval_o,
    output logic                                   resync_o,
    output logic                                   overflow_o,
    output logic [15:0]                            drop_cnt_o
);

    localparam int unsigned PW = $clog2(DEPTH);    // pointer width
    localparam int unsigned CW = PW + 1;           // count holds 0..DEPTH
    localparam int unsigned SW = CW + 1;           // count + batch size without overflow
    localparam int unsigned NE = NR_COMMIT_PORTS + 1;  // ports plus trap slot

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    state_t        r_state;
    logic          r_resync_pend;
    logic          r_overflow;
    logic [15:0]   r_drop_cnt;

    entry_t        w_ent    [NE];
    entry_t        w_wr_ent [NE];
    logic [NE-1:0] w_ent_vld;
    logic [PW-1:0] w_slot   [NE];
    logic [SW-1:0] w_off;
    logic [SW-1:0] w_size;
    logic          w_pop;
    logic          w_fits;
    logic          w_accept;
    logic          w_drop;
    entry_t        w_head;

    // Build the raw batch: one candidate entry per port, then the trap entry.
    always_comb begin
        for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
            w_ent[i]              = '0;
            w_ent[i].iaddr        = MAX_XLEN'(iaddr_i[i]);
            w_ent[i].op           = op_i[i];
            w_ent[i].branch_taken = branch_taken_i[i];
            w_ent_vld[i]          = commit_valid_i[i];
        end
        w_ent[NE-1]           = '0;
        w_ent[NE-1].iaddr     = MAX_XLEN'(epc_i);
        w_ent[NE-1].op        = ADD;
        w_ent[NE-1].exception = exception_i;
        w_ent[NE-1].interrupt = interrupt_i;
        w_ent[NE-1].cause     = cause_i;
        w_ent[NE-1].tval      = MAX_XLEN'(tval_i);
        w_ent_vld[NE-1]       = exception_i | interrupt_i;
    end

    // Compact valid entries into consecutive slots from the write pointer and
    // tag the first one with a pending resync.
    always_comb begin
        // NOTE: w_off is a running prefix sum inside one evaluation, so it must
        // use blocking assignments; each iteration sees the previous update.
        w_off = '0;
        for (int j = 0; j < int'(NE); j++) begin
            w_slot[j]          = r_wr_ptr + w_off[PW-1:0];
            w_wr_ent[j]        = w_ent[j];
            w_wr_ent[j].resync = r_resync_pend && (w_off == '0);
            w_off              = w_off + SW'(w_ent_vld[j]);
        end
        w_size = w_off;
    end

    assign valid_o  = (r_count != '0);
    assign w_pop    = valid_o && ready_i;
    // A pop this cycle frees a slot for the incoming batch.
    assign w_fits   = (SW'(r_count) - SW'(w_pop) + w_size) <= SW'(DEPTH);
    assign w_accept = (r_state == NORMAL) && (w_size != '0) && w_fits;
    assign w_drop   = (w_size != '0) && !w_accept;

    // Entry storage: write every valid entry of an accepted batch.
    // NOTE: the storage array is deliberately not reset; the count alone says
    // which slots hold live data, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk_i) begin
        for (int j = 0; j < int'(NE); j++) begin
            if (w_accept && w_ent_vld[j]) begin
                r_mem[w_slot[j]] <= w_wr_ent[j];
            end
        end
    end

    // Pointers and occupancy count.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + w_size[PW-1:0];
            end
            r_count <= r_count - CW'(w_pop) + (w_accept ? w_size[CW-1:0] : CW'(0));
        end
    end

    // Drop/resync FSM with its registered overflow flag and drop counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= NORMAL;
            r_resync_pend <= 1'b0;
            r_overflow    <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            case (r_state)
                NORMAL: begin
                    if (w_drop) begin
                        r_state <= DROP;
                    end
                    if (w_accept) begin
                        r_resync_pend <= 1'b0;
                    end
                end
                DROP: begin
                    if (r_count == '0) begin
                        r_state       <= NORMAL;
                        r_resync_pend <= 1'b1;
                    end
                end
                default: r_state <= NORMAL;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
        end
    end

    assign w_head         = r_mem[r_rd_ptr];
    assign iaddr_o        = w_head.iaddr[XLEN-1:0];
    assign op_o           = w_head.op;
    assign branch_taken_o = w_head.branch_taken;
    assign exception_o    = w_head.exception;
    assign interrupt_o    = w_head.interrupt;
    assign cause_o        = w_head.cause;
    assign tval_o         = w_head.tval[XLEN-1:0];
    assign resync_o       = valid_o && w_head.resync;
    assign overflow_o     = r_overflow;
    assign drop_cnt_o     = r_drop_cnt;

endmodule
